mcpu_core_d2pc_stage: RTL and testbench
=======================================

# mcpu_core_d2pc_stage

Decode-to-PC pipeline stage: registers decoded operands and control fields and drives the `d2pc_in_*` inputs of the core ALU. Resolves read-after-write hazards by forwarding from the PC→WB and WB→regfile result buses, both when capturing and while an instruction is held by a stall. Uses a valid/ready handshake upstream and downstream, with a flush from branch resolution.

## Interface
- No parameters.
- clkrst_core_clk  in  1  core clock; all state changes on its rising edge.
- clkrst_core_rst  in  1  reset: synchronous, active-high.
- d_valid  in  1  decode offers an instruction.
- d_ready  out  1  stage accepts the instruction this cycle.
- d_rs_num, d_rt_num, d_rd_num  in  5 each  source and destination register numbers.
- d_rs_data, d_rt_data  in  32 each  register-file read data.
- d_imm  in  32  decoded immediate.
- d_use_imm  in  1  second operand is `d_imm`, not rt.
- d_execute_opcode  in  4  ALU opcode.
- d_compare_type  in  3  compare sub-op.
- d_shift_type  in  2  shift type.
- d_shift_amount  in  6  shift amount.
- pc_fwd_valid, pc_fwd_rd, pc_fwd_data  in  1/5/32  PC-stage result bus.
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/5/32  WB-stage result bus.
- pc_ready  in  1  PC stage consumes the held instruction.
- flush  in  1  kill the held instruction and any accept this cycle.
- d2pc_out_valid  out  1  held instruction is valid.
- d2pc_out_rs_data, d2pc_out_sop  out  32 each  ALU operands.
- d2pc_out_execute_opcode  out  4; d2pc_out_compare_type  out  3; d2pc_out_shift_type  out  2; d2pc_out_shift_amount  out  6; d2pc_out_rd_num  out  5  registered control fields.

## Operation
- `d_ready = ~flush & (~d2pc_out_valid | pc_ready)`. This is combinational.
- Accept: `d_valid & d_ready`. On accept, all fields are registered and `d2pc_out_valid` is set to 1.
- Forwarding mux, per source, with r0 as an exception:
  - If `num==0`, data is 0, and the bus is ignored.
  - Otherwise, if `pc_fwd_valid & pc_fwd_rd==num`, use `pc_fwd_data` (youngest wins).
  - Otherwise, if `wb_fwd_valid & wb_fwd_rd==num`, use `wb_fwd_data`.
  - Otherwise, use the register-file data.
- The mux applies to rs and rt on accept.
- Hold snooping: while `d2pc_out_valid & ~pc_ready & ~flush`, the stored rs and rt data are updated each cycle through the same mux, using the stored register numbers and stored data as the fallback.
- Hold snooping also applies to rt when `use_imm=1`. This is harmless, because sop selects imm in that case.
- `d2pc_out_sop = use_imm_q ? imm_q : rt_data_q`. This is the only output logic after the registers.
- Retire with no accept (`pc_ready` and no accept): `d2pc_out_valid` goes to 0. The data registers hold their values.
- Flush has the highest priority. The next `d2pc_out_valid` is 0, and any accept in the same cycle is suppressed.
- The stage never modifies the opcode, compare, or shift fields; invalid encodings are passed through.

## Timing
- Reset: `d2pc_out_valid=0`. All data and field outputs are 0. `d_ready` is 1 from the first cycle after reset unless `flush` is high.
- Reset during a hold drops the instruction; reset takes priority over flush and accept.
- Latency: an instruction accepted at edge N is presented at the outputs from N+1.
- Throughput: 1 per cycle while `pc_ready=1`.
- A simultaneous retire and accept gives back-to-back valid outputs, with no bubble.
- Stall: outputs stay stable except for snoop updates to `rs_data` and `sop`.
- Bypass: a forward bus match in the accept cycle takes effect at the next edge.
- `pc_fwd` and `wb_fwd` naming the same register in the same cycle: `pc_fwd` wins.
- Back-pressure is reflected combinationally: `d_ready` falls in the same cycle that `pc_ready` falls while valid.

## Test plan
- Reset, then accept rs=3 (data 0x10), rt=4 (data 0x20), use_imm=0, opcode 0000 → next cycle valid=1, rs_data=0x10, sop=0x20, fields match.
- Same-cycle forward: accept rs=5 with rf data 0x1, pc_fwd {5, 0xAAAA}, and wb_fwd {5, 0xBBBB} → rs_data=0xAAAA. Repeat with rs=0 and all buses matching 0 → rs_data=0.
- Stall snoop: hold with pc_ready=0 for 3 cycles, stored rt=7, use_imm=0; wb_fwd {7, 0x1234} in cycle 2 → sop=0x1234 from cycle 3; d_ready=0 throughout.
- Back-to-back: pc_ready=1 and d_valid=1 for 4 instructions → 4 consecutive valid outputs, in order, with no bubble.
- Flush: valid held, flush=1 with d_valid=1 → next cycle valid=0, instruction not accepted, d_ready=0 during the flush cycle.
- Reset mid-hold: valid held, assert reset for 1 cycle → valid=0, outputs 0, d_ready=1 after release.

Source files
------------

// File: rtl/mcpu_core_d2pc_stage_if.sv
// Decode/forwarding/PC-stage signal bundle for the decode-to-PC pipeline stage.
// The slave modport is the stage itself. The master modport is the surrounding core.
interface mcpu_core_d2pc_stage_if;
  logic        d_valid;
  logic        d_ready;
  logic [4:0]  d_rs_num;
  logic [4:0]  d_rt_num;
  logic [4:0]  d_rd_num;
  logic [31:0] d_rs_data;
  logic [31:0] d_rt_data;
  logic [31:0] d_imm;
  logic        d_use_imm;
  logic [3:0]  d_execute_opcode;
  logic [2:0]  d_compare_type;
  logic [1:0]  d_shift_type;
  logic [5:0]  d_shift_amount;
  logic        pc_fwd_valid;
  logic [4:0]  pc_fwd_rd;
  logic [31:0] pc_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        pc_ready;
  logic        flush;
  logic        d2pc_out_valid;
  logic [31:0] d2pc_out_rs_data;
  logic [31:0] d2pc_out_sop;
  logic [3:0]  d2pc_out_execute_opcode;
  logic [2:0]  d2pc_out_compare_type;
  logic [1:0]  d2pc_out_shift_type;
  logic [5:0]  d2pc_out_shift_amount;
  logic [4:0]  d2pc_out_rd_num;

  modport slave (
    input  d_valid, d_rs_num, d_rt_num, d_rd_num, d_rs_data, d_rt_data, d_imm,
           d_use_imm, d_execute_opcode, d_compare_type, d_shift_type, d_shift_amount,
           pc_fwd_valid, pc_fwd_rd, pc_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
           pc_ready, flush,
    output d_ready, d2pc_out_valid, d2pc_out_rs_data, d2pc_out_sop,
           d2pc_out_execute_opcode, d2pc_out_compare_type, d2pc_out_shift_type,
           d2pc_out_shift_amount, d2pc_out_rd_num
  );

  modport master (
    output d_valid, d_rs_num, d_rt_num, d_rd_num, d_rs_data, d_rt_data, d_imm,
           d_use_imm, d_execute_opcode, d_compare_type, d_shift_type, d_shift_amount,
           pc_fwd_valid, pc_fwd_rd, pc_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
           pc_ready, flush,
    input  d_ready, d2pc_out_valid, d2pc_out_rs_data, d2pc_out_sop,
           d2pc_out_execute_opcode, d2pc_out_compare_type, d2pc_out_shift_type,
           d2pc_out_shift_amount, d2pc_out_rd_num
  );
endinterface

// File: rtl/mcpu_core_d2pc_stage.sv
// Decode-to-PC pipeline register. It forwards results from the PC and WB buses on capture,
// and keeps snooping those buses while the held instruction is stalled.
module mcpu_core_d2pc_stage (
  input  logic                         clkrst_core_clk,
  input  logic                         clkrst_core_rst,
  mcpu_core_d2pc_stage_if.slave        bus
);

  logic        valid_q;
  logic [4:0]  rs_num_q;
  logic [4:0]  rt_num_q;
  logic [4:0]  rd_num_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;
  logic        use_imm_q;
  logic [3:0]  opcode_q;
  logic [2:0]  compare_q;
  logic [1:0]  shift_type_q;
  logic [5:0]  shift_amount_q;

  logic        accept;
  logic        hold;
  logic [31:0] rs_accept_data;
  logic [31:0] rt_accept_data;
  logic [31:0] rs_snoop_data;
  logic [31:0] rt_snoop_data;

  // r0 always reads as zero. The PC bus is younger than the WB bus, so it wins.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  num,
    input logic [31:0] fallback,
    input logic        pc_v,
    input logic [4:0]  pc_rd,
    input logic [31:0] pc_d,
    input logic        wb_v,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_d
  );
    if (num == 5'd0)
      return '0;
    else if (pc_v && (pc_rd == num))
      return pc_d;
    else if (wb_v && (wb_rd == num))
      return wb_d;
    else
      return fallback;
  endfunction

  assign bus.d_ready = ~bus.flush & (~valid_q | bus.pc_ready);
  assign accept      = bus.d_valid & bus.d_ready;
  assign hold        = valid_q & ~bus.pc_ready & ~bus.flush;

  always_comb begin
    rs_accept_data = fwd_sel(bus.d_rs_num, bus.d_rs_data,
                             bus.pc_fwd_valid, bus.pc_fwd_rd, bus.pc_fwd_data,
                             bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    rt_accept_data = fwd_sel(bus.d_rt_num, bus.d_rt_data,
                             bus.pc_fwd_valid, bus.pc_fwd_rd, bus.pc_fwd_data,
                             bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    rs_snoop_data  = fwd_sel(rs_num_q, rs_data_q,
                             bus.pc_fwd_valid, bus.pc_fwd_rd, bus.pc_fwd_data,
                             bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    rt_snoop_data  = fwd_sel(rt_num_q, rt_data_q,
                             bus.pc_fwd_valid, bus.pc_fwd_rd, bus.pc_fwd_data,
                             bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      valid_q        <= 1'b0;
      rs_num_q       <= '0;
      rt_num_q       <= '0;
      rd_num_q       <= '0;
      rs_data_q      <= '0;
      rt_data_q      <= '0;
      imm_q          <= '0;
      use_imm_q      <= 1'b0;
      opcode_q       <= '0;
      compare_q      <= '0;
      shift_type_q   <= '0;
      shift_amount_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q        <= 1'b1;
      rs_num_q       <= bus.d_rs_num;
      rt_num_q       <= bus.d_rt_num;
      rd_num_q       <= bus.d_rd_num;
      rs_data_q      <= rs_accept_data;
      rt_data_q      <= rt_accept_data;
      imm_q          <= bus.d_imm;
      use_imm_q      <= bus.d_use_imm;
      opcode_q       <= bus.d_execute_opcode;
      compare_q      <= bus.d_compare_type;
      shift_type_q   <= bus.d_shift_type;
      shift_amount_q <= bus.d_shift_amount;
    end else if (hold) begin
      // rt keeps snooping even when the immediate is selected; sop ignores it then.
      rs_data_q <= rs_snoop_data;
      rt_data_q <= rt_snoop_data;
    end else if (bus.pc_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.d2pc_out_valid          = valid_q;
  assign bus.d2pc_out_rs_data        = rs_data_q;
  assign bus.d2pc_out_sop            = use_imm_q ? imm_q : rt_data_q;
  assign bus.d2pc_out_execute_opcode = opcode_q;
  assign bus.d2pc_out_compare_type   = compare_q;
  assign bus.d2pc_out_shift_type     = shift_type_q;
  assign bus.d2pc_out_shift_amount   = shift_amount_q;
  assign bus.d2pc_out_rd_num         = rd_num_q;

endmodule

// File: tb/tb_mcpu_core_d2pc_stage.sv
// Bench for mcpu_core_d2pc_stage. It applies a directed vector table and then random traffic
// checked against a held-instruction model.
module tb_mcpu_core_d2pc_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcpu_core_d2pc_stage_if bus ();

  mcpu_core_d2pc_stage dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .bus             (bus.slave)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  typedef struct {
    logic        rst, dv;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        ui;
    logic [3:0]  op;
    logic        pcv;
    logic [4:0]  pcrd;
    logic [31:0] pcd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        prdy, fl;
    logic        e_ready, e_valid;
    logic [31:0] e_rs, e_sop;
    logic [3:0]  e_op;
  } vec_t;

  // The model holds the in-flight instruction: its operand registers, resolved values and fields.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic        ui;
    logic [3:0]  op;
    logic [2:0]  cmp;
    logic [1:0]  sht;
    logic [5:0]  sha;
  } instr_t;

  instr_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a register holds as seen this cycle: r0 is zero, the youngest bus match wins,
  // and otherwise the given value is used.
  function automatic logic [31:0] reg_value(input logic [4:0] n, input logic [31:0] dflt);
    logic [31:0] v;
    v = dflt;
    if (bus.wb_fwd_valid && bus.wb_fwd_rd == n) v = bus.wb_fwd_data;
    if (bus.pc_fwd_valid && bus.pc_fwd_rd == n) v = bus.pc_fwd_data;
    if (n == 5'd0) v = 32'd0;
    return v;
  endfunction

  function automatic logic model_ready();
    return !bus.flush && (!m.valid || bus.pc_ready);
  endfunction

  task automatic model_edge();
    logic took;
    took = model_ready() && bus.d_valid;
    if (rst) begin
      m = '{default: '0};
    end else if (bus.flush) begin
      m.valid = 1'b0;
    end else if (took) begin
      m.valid  = 1'b1;
      m.rs = bus.d_rs_num; m.rt = bus.d_rt_num; m.rd = bus.d_rd_num;
      m.rs_val = reg_value(bus.d_rs_num, bus.d_rs_data);
      m.rt_val = reg_value(bus.d_rt_num, bus.d_rt_data);
      m.imm = bus.d_imm; m.ui = bus.d_use_imm; m.op = bus.d_execute_opcode;
      m.cmp = bus.d_compare_type; m.sht = bus.d_shift_type; m.sha = bus.d_shift_amount;
    end else if (m.valid && !bus.pc_ready) begin
      m.rs_val = reg_value(m.rs, m.rs_val);
      m.rt_val = reg_value(m.rt, m.rt_val);
    end else if (bus.pc_ready) begin
      m.valid = 1'b0;
    end
  endtask

  task automatic drive(input vec_t v);
    rst                  = v.rst;
    bus.d_valid          = v.dv;
    bus.d_rs_num         = v.rs;
    bus.d_rt_num         = v.rt;
    bus.d_rd_num         = v.rd;
    bus.d_rs_data        = v.rsd;
    bus.d_rt_data        = v.rtd;
    bus.d_imm            = v.imm;
    bus.d_use_imm        = v.ui;
    bus.d_execute_opcode = v.op;
    bus.d_compare_type   = 3'd0;
    bus.d_shift_type     = 2'd0;
    bus.d_shift_amount   = 6'd0;
    bus.pc_fwd_valid     = v.pcv;
    bus.pc_fwd_rd        = v.pcrd;
    bus.pc_fwd_data      = v.pcd;
    bus.wb_fwd_valid     = v.wbv;
    bus.wb_fwd_rd        = v.wbrd;
    bus.wb_fwd_data      = v.wbd;
    bus.pc_ready         = v.prdy;
    bus.flush            = v.fl;
  endtask

  function automatic vec_t mk(
    input logic r, input logic dv, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm, input logic ui,
    input logic [3:0] op, input logic pcv, input logic [4:0] pcrd, input logic [31:0] pcd,
    input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd, input logic prdy,
    input logic fl, input logic er, input logic ev, input logic [31:0] ers,
    input logic [31:0] esop, input logic [3:0] eop);
    vec_t v;
    v.rst = r; v.dv = dv; v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd;
    v.imm = imm; v.ui = ui; v.op = op; v.pcv = pcv; v.pcrd = pcrd; v.pcd = pcd;
    v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.prdy = prdy; v.fl = fl;
    v.e_ready = er; v.e_valid = ev; v.e_rs = ers; v.e_sop = esop; v.e_op = eop;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //          rst dv rs  rt  rd  rsd     rtd     imm     ui op  pcv pcrd pcd   wbv wbrd wbd   prdy fl | rdy val rs     sop     op
    tbl.push_back(mk(0,1, 3, 4, 9, 32'h10, 32'h20, 32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,1, 32'h10, 32'h20, 0));
    tbl.push_back(mk(0,1, 5, 6, 2, 32'h1,  32'h66, 32'h0,   0,3,  1,5, 32'hAAAA, 1,5, 32'hBBBB, 1,0, 1,1, 32'hAAAA,32'h66,3));
    tbl.push_back(mk(0,1, 0, 0, 1, 32'h55, 32'h77, 32'h0,   0,5,  1,0, 32'h999,  1,0, 32'h888,  1,0, 1,1, 32'h0,  32'h0,  5));
    tbl.push_back(mk(0,1, 1, 7, 3, 32'h11, 32'h70, 32'h0,   0,2,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,1, 32'h11, 32'h70, 2));
    tbl.push_back(mk(0,1,30,29, 4, 32'hDEAD,32'hBEEF,32'h0, 0,9,  0,0, 32'h0,    0,0, 32'h0,    0,0, 0,1, 32'h11, 32'h70, 2));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    1,7, 32'h1234, 0,0, 0,1, 32'h11, 32'h1234,2));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    0,0, 0,1, 32'h11, 32'h1234,2));
    tbl.push_back(mk(0,1, 2, 3, 5, 32'h22, 32'h33, 32'hCAFE,1,7,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,1, 32'h22, 32'hCAFE,7));
    tbl.push_back(mk(0,1, 8, 9, 6, 32'h80, 32'h90, 32'h0,   0,8,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,1, 32'h80, 32'h90, 8));
    tbl.push_back(mk(0,1,10,11, 7, 32'hA0, 32'hB0, 32'h0,   0,9,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,1, 32'hA0, 32'hB0, 9));
    tbl.push_back(mk(0,1,12,13, 8, 32'hC0, 32'hD0, 32'h0,   0,10, 0,0, 32'h0,    0,0, 32'h0,    1,0, 1,1, 32'hC0, 32'hD0, 10));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    0,0, 0,1, 32'hC0, 32'hD0, 10));
    tbl.push_back(mk(0,1,14,15, 9, 32'hE0, 32'hE1, 32'h0,   0,15, 0,0, 32'h0,    0,0, 32'h0,    0,1, 0,0, 32'hC0, 32'hD0, 10));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    0,0, 1,0, 32'hC0, 32'hD0, 10));
    tbl.push_back(mk(0,1,15,16,10, 32'hF0, 32'h16, 32'h0,   0,1,  0,0, 32'h0,    0,0, 32'h0,    0,0, 1,1, 32'hF0, 32'h16, 1));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,0, 32'hF0, 32'h16, 1));
    tbl.push_back(mk(0,1,17,18,11, 32'h170,32'h180,32'h0,   0,4,  0,0, 32'h0,    0,0, 32'h0,    0,0, 1,1, 32'h170,32'h180,4));
    tbl.push_back(mk(1,1, 1, 2, 3, 32'h5,  32'h6,  32'h0,   0,3,  0,0, 32'h0,    0,0, 32'h0,    0,0, 0,0, 32'h0,  32'h0,  0));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    0,0, 1,0, 32'h0,  32'h0,  0));
    tbl.push_back(mk(0,1,20,21,12, 32'h1,  32'h2,  32'h0,   0,6,  0,0, 32'h0,    1,21,32'h2121, 0,0, 1,1, 32'h1,  32'h2121,6));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  1,20,32'h5,    1,20,32'h6,    0,0, 0,1, 32'h5,  32'h2121,6));
    tbl.push_back(mk(0,0, 0, 0, 0, 32'h0,  32'h0,  32'h0,   0,0,  0,0, 32'h0,    0,0, 32'h0,    1,0, 1,0, 32'h5,  32'h2121,6));

    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    m = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_valid", {31'd0, bus.d2pc_out_valid}, 32'd0);
    chk("reset_rs",    bus.d2pc_out_rs_data, 32'd0);
    chk("reset_sop",   bus.d2pc_out_sop, 32'd0);
    chk("reset_rd",    {27'd0, bus.d2pc_out_rd_num}, 32'd0);
    chk("reset_ready", {31'd0, bus.d_ready}, 32'd1);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, bus.d_ready}, {31'd0, tbl[i].e_ready});
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.d2pc_out_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_rs", i), bus.d2pc_out_rs_data, tbl[i].e_rs);
      chk($sformatf("v%0d_sop", i), bus.d2pc_out_sop, tbl[i].e_sop);
      chk($sformatf("v%0d_op", i), {28'd0, bus.d2pc_out_execute_opcode}, {28'd0, tbl[i].e_op});
    end

    for (int unsigned c = 0; c < 400; c++) begin
      rst                  = ($urandom_range(63) == 0);
      bus.d_valid          = ($urandom_range(9) < 7);
      bus.d_rs_num         = 5'($urandom_range(7));
      bus.d_rt_num         = 5'($urandom_range(7));
      bus.d_rd_num         = 5'($urandom);
      bus.d_rs_data        = $urandom;
      bus.d_rt_data        = $urandom;
      bus.d_imm            = $urandom;
      bus.d_use_imm        = 1'($urandom);
      bus.d_execute_opcode = 4'($urandom);
      bus.d_compare_type   = 3'($urandom);
      bus.d_shift_type     = 2'($urandom);
      bus.d_shift_amount   = 6'($urandom);
      bus.pc_fwd_valid     = 1'($urandom);
      bus.pc_fwd_rd        = 5'($urandom_range(7));
      bus.pc_fwd_data      = $urandom;
      bus.wb_fwd_valid     = 1'($urandom);
      bus.wb_fwd_rd        = 5'($urandom_range(7));
      bus.wb_fwd_data      = $urandom;
      bus.pc_ready         = 1'($urandom);
      bus.flush            = ($urandom_range(7) == 0);
      #1;
      chk("rnd_ready", {31'd0, bus.d_ready}, {31'd0, model_ready()});
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_valid", {31'd0, bus.d2pc_out_valid}, {31'd0, m.valid});
      chk("rnd_rs",    bus.d2pc_out_rs_data, m.rs_val);
      chk("rnd_sop",   bus.d2pc_out_sop, m.ui ? m.imm : m.rt_val);
      chk("rnd_fields",
          {12'd0, bus.d2pc_out_execute_opcode, bus.d2pc_out_compare_type,
           bus.d2pc_out_shift_type, bus.d2pc_out_shift_amount, bus.d2pc_out_rd_num},
          {12'd0, m.op, m.cmp, m.sht, m.sha, m.rd});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
